// File: rtl/cog_frame_ctrl.sv
// cog_frame_ctrl: gates a camera AXI-Stream into the CoG pipeline on frame boundaries,
// counts input lines/frames, tracks returned result frames and drains before completion.
module cog_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_BEATS = 640,
    parameter int unsigned HEIGHT     = 1024,
    parameter int unsigned TIMEOUT    = 2**20
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_aresetn,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [15:0]             i_frame_count,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    i_res_tvalid,
    input  logic                    i_res_tlast,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [15:0]             o_frames_done,
    output logic                    o_err_width,
    output logic                    o_err_sof,
    output logic                    o_timeout
);
    localparam int unsigned PIX_W  = $clog2(LINE_BEATS + 1);
    localparam int unsigned LINE_W = $clog2(HEIGHT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_BEATS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StArm, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LINE_W-1:0]  res_line_q, res_line_d;
    logic [15:0]        frames_sent_q, frames_sent_d;
    logic [15:0]        frames_done_q, frames_done_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               stop_q, stop_d;
    logic               err_width_q, err_width_d;
    logic               err_sof_q, err_sof_d;
    logic               timeout_q, timeout_d;

    logic gate_open;
    logic beat_acc;
    logic last_frame;

    // In ARM the gate opens only on the SOF beat so the pipeline sees whole frames.
    assign gate_open     = (state_q == StRun) || ((state_q == StArm) && s_axis_tuser);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser & gate_open;
    assign m_axis_tlast  = s_axis_tlast & gate_open;
    assign m_axis_tvalid = s_axis_tvalid & gate_open;
    assign s_axis_tready = gate_open ? m_axis_tready : 1'b1;
    assign beat_acc      = gate_open & s_axis_tvalid & m_axis_tready;

    // Frame in flight is the last requested one (frame_count 0 means run until stopped).
    assign last_frame = (i_frame_count != 16'd0) &&
                        (({1'b0, frames_sent_q} + 17'd1) == {1'b0, i_frame_count});

    assign o_busy        = (state_q == StArm) || (state_q == StRun) || (state_q == StDrain);
    assign o_done        = (state_q == StDone);
    assign o_frames_done = frames_done_q;
    assign o_err_width   = err_width_q;
    assign o_err_sof     = err_sof_q;
    assign o_timeout     = timeout_q;

    // Next-state logic for the FSM, input accounting, result monitor and drain timer.
    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        line_d        = line_q;
        res_line_d    = res_line_q;
        frames_sent_d = frames_sent_q;
        frames_done_d = frames_done_q;
        to_d          = '0;
        stop_d        = stop_q;
        err_width_d   = err_width_q;
        err_sof_d     = err_sof_q;
        timeout_d     = timeout_q;

        if (o_busy && i_res_tvalid && i_res_tlast) begin
            if (res_line_q == LINE_LAST) begin
                res_line_d = '0;
                if (frames_done_q != '1) frames_done_d = frames_done_q + 1'b1;
            end else if (res_line_q != '1) begin
                res_line_d = res_line_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    pix_d         = '0;
                    line_d        = '0;
                    res_line_d    = '0;
                    frames_sent_d = '0;
                    frames_done_d = '0;
                    stop_d        = 1'b0;
                    err_width_d   = 1'b0;
                    err_sof_d     = 1'b0;
                    timeout_d     = 1'b0;
                    state_d       = StArm;
                end
            end
            StArm: begin
                if (beat_acc) begin
                    // SOF beat is beat 0 of line 0; a coincident stop waits for frame end.
                    pix_d   = PIX_W'(1);
                    line_d  = '0;
                    stop_d  = stop_q | i_stop;
                    state_d = StRun;
                end else if (i_stop) begin
                    state_d = StDrain;
                end
            end
            StRun: begin
                if (i_stop) stop_d = 1'b1;
                if (beat_acc) begin
                    if (s_axis_tuser && ((pix_q != '0) || (line_q != '0))) begin
                        // Unexpected SOF: resynchronise on it as the new beat 0.
                        err_sof_d = 1'b1;
                        pix_d     = PIX_W'(1);
                        line_d    = '0;
                    end else if (s_axis_tlast) begin
                        if (pix_q != PIX_LAST) err_width_d = 1'b1;
                        pix_d = '0;
                        if (line_q == LINE_LAST) begin
                            line_d = '0;
                            if (frames_sent_q != '1) frames_sent_d = frames_sent_q + 1'b1;
                            state_d = (stop_q || i_stop || last_frame) ? StDrain : StArm;
                        end else if (line_q != '1) begin
                            line_d = line_q + 1'b1;
                        end
                    end else begin
                        if (pix_q == PIX_LAST) err_width_d = 1'b1;
                        if (pix_q != '1) pix_d = pix_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (frames_done_q == frames_sent_q) begin
                    state_d = StDone;
                end else if (to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_aresetn) begin
            state_q       <= StIdle;
            pix_q         <= '0;
            line_q        <= '0;
            res_line_q    <= '0;
            frames_sent_q <= '0;
            frames_done_q <= '0;
            to_q          <= '0;
            stop_q        <= 1'b0;
            err_width_q   <= 1'b0;
            err_sof_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            line_q        <= line_d;
            res_line_q    <= res_line_d;
            frames_sent_q <= frames_sent_d;
            frames_done_q <= frames_done_d;
            to_q          <= to_d;
            stop_q        <= stop_d;
            err_width_q   <= err_width_d;
            err_sof_q     <= err_sof_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule
